// File: rtl/config_uart_tx.sv
// Configuration-link UART transmitter: 32-bit words buffered in a small FIFO, sent MSB byte first as 8N1 frames.
// Define CONFIG_UART_TX_PARITY_EN to insert an even-parity bit per byte (8E1).
module config_uart_tx #(
  parameter int CLK_DIV    = 217,
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW    = 2
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic [31:0]        WordData,
  input  logic               WordValid,
  output logic               WordReady,
  output logic               Tx,
  output logic               TxBusy,
  output logic [FIFO_AW:0]   FifoLevel
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef CONFIG_UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  localparam logic [15:0]      LP_BAUD_LOAD = 16'(CLK_DIV - 1);
  localparam logic [FIFO_AW:0] LP_DEPTH     = (FIFO_AW + 1)'(FIFO_DEPTH);

  logic [31:0]        r_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]   r_level;
  logic               r_full;

  state_t             r_state;
  logic [15:0]        r_baud;
  logic [31:0]        r_word;
  logic [7:0]         r_shift;
  logic [2:0]         r_bit_cnt;
  logic [1:0]         r_idx;
  logic               r_tx;
`ifdef CONFIG_UART_TX_PARITY_EN
  logic               r_parity;
`endif

  logic               w_push;
  logic               w_pop;
  logic [FIFO_AW:0]   w_level_nxt;
  logic [7:0]         w_byte;
  logic               w_baud_done;

  // Pops only happen from IDLE, so a full FIFO can never accept a word in a pop cycle.
  assign w_push      = WordValid && !r_full;
  assign w_pop       = (r_state == S_IDLE) && (r_level != '0);
  assign w_level_nxt = r_level + {{FIFO_AW{1'b0}}, w_push} - {{FIFO_AW{1'b0}}, w_pop};
  assign w_baud_done = (r_baud == 16'd0);

  always_comb begin
    w_byte = r_word[31:24];
    case (r_idx)
      2'd0: w_byte = r_word[31:24];
      2'd1: w_byte = r_word[23:16];
      2'd2: w_byte = r_word[15:8];
      2'd3: w_byte = r_word[7:0];
      default: w_byte = r_word[31:24];
    endcase
  end

  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= WordData;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == LP_DEPTH);
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_tx      <= 1'b1;
      r_baud    <= 16'd0;
      r_word    <= 32'd0;
      r_shift   <= 8'd0;
      r_bit_cnt <= 3'd0;
      r_idx     <= 2'd0;
`ifdef CONFIG_UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_word  <= r_mem[r_rd_ptr];
            r_idx   <= 2'd0;
            r_baud  <= LP_BAUD_LOAD;
            r_tx    <= 1'b0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_baud_done) begin
            // Bit 0 goes straight to the line; the shifter holds the remaining bits.
            r_tx      <= w_byte[0];
            r_shift   <= {1'b0, w_byte[7:1]};
            r_bit_cnt <= 3'd0;
            r_baud    <= LP_BAUD_LOAD;
`ifdef CONFIG_UART_TX_PARITY_EN
            r_parity  <= ^w_byte;
`endif
            r_state   <= S_DATA;
          end else begin
            r_baud <= r_baud - 16'd1;
          end
        end
        S_DATA: begin
          if (w_baud_done) begin
            r_baud <= LP_BAUD_LOAD;
            if (r_bit_cnt == 3'd7) begin
`ifdef CONFIG_UART_TX_PARITY_EN
              r_tx    <= r_parity;
              r_state <= S_PARITY;
`else
              r_tx    <= 1'b1;
              r_state <= S_STOP;
`endif
            end else begin
              r_tx      <= r_shift[0];
              r_shift   <= r_shift >> 1;
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end else begin
            r_baud <= r_baud - 16'd1;
          end
        end
`ifdef CONFIG_UART_TX_PARITY_EN
        S_PARITY: begin
          if (w_baud_done) begin
            r_baud  <= LP_BAUD_LOAD;
            r_tx    <= 1'b1;
            r_state <= S_STOP;
          end else begin
            r_baud <= r_baud - 16'd1;
          end
        end
`endif
        S_STOP: begin
          if (w_baud_done) begin
            if (r_idx != 2'd3) begin
              r_idx   <= r_idx + 2'd1;
              r_baud  <= LP_BAUD_LOAD;
              r_tx    <= 1'b0;
              r_state <= S_START;
            end else begin
              r_tx    <= 1'b1;
              r_state <= S_IDLE;
            end
          end else begin
            r_baud <= r_baud - 16'd1;
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign WordReady = !r_full;
  assign Tx        = r_tx;
  assign TxBusy    = (r_state != S_IDLE) || (r_level != '0);
  assign FifoLevel = r_level;

endmodule

// File: tb/tb_config_uart_tx.sv
// Bench for config_uart_tx: stimulus pushes expected bytes into a queue; a Tx decoder pops and compares.
module tb_config_uart_tx;
  localparam int CLK_DIV = 4;
  localparam int DEPTH   = 4;
  localparam int AW      = 2;
`ifdef CONFIG_UART_TX_PARITY_EN
  localparam int FRAME = 11 * CLK_DIV;
`else
  localparam int FRAME = 10 * CLK_DIV;
`endif
  localparam int WORD_CYC = 4 * FRAME;

  logic          CLK = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   WordData = 32'd0;
  logic          WordValid = 1'b0;
  logic          WordReady;
  logic          Tx;
  logic          TxBusy;
  logic [AW:0]   FifoLevel;

  config_uart_tx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH), .FIFO_AW(AW)) dut (
    .CLK(CLK), .reset(reset), .WordData(WordData), .WordValid(WordValid),
    .WordReady(WordReady), .Tx(Tx), .TxBusy(TxBusy), .FifoLevel(FifoLevel)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  logic [7:0] exp_q[$];
  int         starts[$];
  logic       pbits[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Tx decoder: samples each bit mid-period, compares against the scoreboard.
  logic       m_busy = 1'b0;
  int         m_t = 0;
  logic [7:0] m_byte = 8'd0;
  logic [7:0] m_exp;
  always @(negedge CLK) begin
    if (reset) begin
      m_busy = 1'b0;
    end else if (!m_busy) begin
      if (Tx == 1'b0) begin
        m_busy = 1'b1;
        m_t = 0;
        m_byte = 8'd0;
        starts.push_back(cyc);
      end
    end else begin
      m_t++;
      if (m_t == CLK_DIV / 2) chk("start_bit", {31'd0, Tx}, 32'd0);
      if (m_t > CLK_DIV && m_t < 9 * CLK_DIV && (m_t % CLK_DIV) == CLK_DIV / 2)
        m_byte = {Tx, m_byte[7:1]};
`ifdef CONFIG_UART_TX_PARITY_EN
      if (m_t == 9 * CLK_DIV + CLK_DIV / 2) begin
        pbits.push_back(Tx);
        chk("parity_bit", {31'd0, Tx}, {31'd0, ^m_byte});
      end
`endif
      if (m_t == FRAME - CLK_DIV + CLK_DIV / 2) begin
        chk("stop_bit", {31'd0, Tx}, 32'd1);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_byte actual=0x%0h required=none", m_byte);
        end else begin
          m_exp = exp_q.pop_front();
          chk("byte", {24'd0, m_byte}, {24'd0, m_exp});
        end
      end
      if (m_t == FRAME - 1) m_busy = 1'b0;
    end
  end

  task automatic push(input logic [31:0] w);
    int n;
    n = 0;
    WordData  = w;
    WordValid = 1'b1;
    while (!WordReady && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 2000) begin
      checks++;
      failures++;
      $display("FAIL push_timeout actual=ready_low required=accept");
      WordValid = 1'b0;
    end else begin
      @(posedge CLK);
      exp_q.push_back(w[31:24]);
      exp_q.push_back(w[23:16]);
      exp_q.push_back(w[15:8]);
      exp_q.push_back(w[7:0]);
      @(negedge CLK);
    end
  endtask

  task automatic wait_idle(output int fall);
    int n;
    n = 0;
    while (TxBusy !== 1'b0 && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 3000) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout actual=busy required=idle");
    end
    fall = cyc;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int fall;
    int acc;
    int n;

    repeat (3) @(negedge CLK);
    reset = 1'b0;
    chk("rst_tx", {31'd0, Tx}, 32'd1);
    chk("rst_ready", {31'd0, WordReady}, 32'd1);
    chk("rst_busy", {31'd0, TxBusy}, 32'd0);
    chk("rst_level", {29'd0, FifoLevel}, 32'd0);

    // Single word
    starts.delete();
    push(32'hFAB0FAB1);
    WordValid = 1'b0;
    wait_idle(fall);
    chk("single_nbytes", starts.size(), 4);
    if (starts.size() == 4) begin
      chk("single_duration", fall - starts[0], WORD_CYC);
      chk("single_byte_spacing", starts[3] - starts[0], 3 * FRAME);
    end
    chk("single_tx_idle", {31'd0, Tx}, 32'd1);

    // Back-to-back
    starts.delete();
    push(32'h12345678);
    push(32'hDEADBEEF);
    WordValid = 1'b0;
    wait_idle(fall);
    chk("b2b_nbytes", starts.size(), 8);
    if (starts.size() == 8) begin
      chk("b2b_gap", starts[4] - starts[3], FRAME + 1);
      chk("b2b_duration", fall - starts[4], WORD_CYC);
    end

    // Full FIFO
    starts.delete();
    push(32'hA0A1A2A3);
    push(32'hB0B1B2B3);
    push(32'hC0C1C2C3);
    push(32'hD0D1D2D3);
    push(32'hE0E1E2E3);
    chk("full_level", {29'd0, FifoLevel}, 32'd4);
    chk("full_ready", {31'd0, WordReady}, 32'd0);
    push(32'h0F1E2D3C);
    acc = cyc;
    chk("full_refill_level", {29'd0, FifoLevel}, 32'd4);
    if (starts.size() >= 5) chk("full_accept_after_pop", acc, starts[4] + 1);
    else chk("full_accept_nstarts", starts.size(), 5);
    WordValid = 1'b0;
    wait_idle(fall);
    chk("full_nbytes", starts.size(), 24);

    // Simultaneous push/pop at level 1 with FSM idle
    starts.delete();
    push(32'h01020304);
    chk("pp_level_before", {29'd0, FifoLevel}, 32'd1);
    push(32'h80402010);
    chk("pp_level_after", {29'd0, FifoLevel}, 32'd1);
    WordValid = 1'b0;
    wait_idle(fall);
    chk("pp_nbytes", starts.size(), 8);
    chk("pp_exp_empty", exp_q.size(), 0);

    // Reset during byte1 data bits
    starts.delete();
    push(32'hA5C30F96);
    push(32'h11111111);
    WordValid = 1'b0;
    n = 0;
    while (starts.size() < 2 && n < 1000) begin
      @(negedge CLK);
      n++;
    end
    chk("rstmid_reached_byte1", {31'd0, starts.size() >= 2}, 32'd1);
    repeat (3 * CLK_DIV) @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);
    chk("rstmid_tx", {31'd0, Tx}, 32'd1);
    chk("rstmid_level", {29'd0, FifoLevel}, 32'd0);
    chk("rstmid_busy", {31'd0, TxBusy}, 32'd0);
    @(negedge CLK);
    reset = 1'b0;
    exp_q.delete();
    n = starts.size();
    repeat (300) @(negedge CLK);
    chk("rstmid_no_start", starts.size(), n);
    chk("rstmid_tx_idle", {31'd0, Tx}, 32'd1);
    chk("rstmid_ready", {31'd0, WordReady}, 32'd1);

`ifdef CONFIG_UART_TX_PARITY_EN
    starts.delete();
    pbits.delete();
    push(32'h00000007);
    WordValid = 1'b0;
    wait_idle(fall);
    chk("par_nbits", pbits.size(), 4);
    if (pbits.size() == 4 && starts.size() == 4) begin
      chk("par_b0", {31'd0, pbits[0]}, 32'd0);
      chk("par_b1", {31'd0, pbits[1]}, 32'd0);
      chk("par_b2", {31'd0, pbits[2]}, 32'd0);
      chk("par_b3", {31'd0, pbits[3]}, 32'd1);
      chk("par_duration", fall - starts[0], 176);
    end
`endif

    chk("final_exp_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
